// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB that tags dispatched instructions, captures CDB results and retires the head.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int REG_NUM = 32,
  parameter int READ_PORTS = 2,
  parameter int CDB_SIZE = 2,
  localparam int IW = $clog2(DEPTH),
  localparam int RW = $clog2(REG_NUM),
  localparam int CW = 33 + IW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  input  logic [RW-1:0]              dispatch_dest,
  output logic                       dispatch_ready,
  output logic [IW-1:0]              dispatch_index,
  input  logic [CDB_SIZE*CW-1:0]     cdb,
  input  logic                       commit_stall,
  output logic                       commit_valid,
  output logic                       commit_we,
  output logic [RW-1:0]              commit_waddr,
  output logic [31:0]                commit_wdata,
  output logic                       wrst,
  output logic [IW-1:0]              wreorder,
  input  logic [READ_PORTS*IW-1:0]   raddr,
  output logic [READ_PORTS*32-1:0]   rdata,
  output logic [READ_PORTS-1:0]      rready,
  output logic                       empty
);
  logic [DEPTH-1:0] valid, done;
  logic [RW-1:0] dest [DEPTH];
  logic [31:0] value [DEPTH];
  logic [IW-1:0] head, tail;
  logic [IW:0] count;
  logic alloc;
  assign dispatch_ready = count != (IW+1)'(DEPTH);
  assign dispatch_index = tail;
  assign alloc = dispatch_valid && dispatch_ready;
  assign commit_valid = valid[head] && done[head] && !commit_stall;
  assign commit_we = commit_valid && dest[head] != '0;
  assign commit_waddr = dest[head];
  assign commit_wdata = value[head];
  assign wrst = commit_valid;
  assign wreorder = head;
  assign empty = count == '0;
  for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
    assign rdata[g*32 +: 32] = value[raddr[g*IW +: IW]];
    assign rready[g] = valid[raddr[g*IW +: IW]] && done[raddr[g*IW +: IW]];
  end
  // The tail slot is always invalid when allocation is allowed, so a CDB hit on it is ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest[i] <= '0;
        value[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest[i] <= '0;
        value[i] <= '0;
      end
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        done[tail] <= 1'b0;
        dest[tail] <= dispatch_dest;
        value[tail] <= '0;
        tail <= tail + 1'b1;
      end
      for (int j = 0; j < CDB_SIZE; j++)
        if (cdb[j*CW+CW-1] && valid[cdb[j*CW+32 +: IW]] && !done[cdb[j*CW+32 +: IW]]) begin
          value[cdb[j*CW+32 +: IW]] <= cdb[j*CW +: 32];
          done[cdb[j*CW+32 +: IW]] <= 1'b1;
        end
      if (commit_valid) begin
        valid[head] <= 1'b0;
        head <= head + 1'b1;
      end
      count <= count + (IW+1)'(alloc) - (IW+1)'(commit_valid);
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: vector table, corner sequences and random traffic against a queue-based model.
module tb_reorder_buffer;
  localparam int CW = 35;
  logic clk, rst, flush, dispatch_valid, dispatch_ready, commit_stall, commit_valid, commit_we, wrst, empty;
  logic [4:0] dispatch_dest, commit_waddr;
  logic [1:0] dispatch_index, wreorder;
  logic [2*CW-1:0] cdb;
  logic [31:0] commit_wdata;
  logic [3:0] raddr;
  logic [63:0] rdata;
  logic [1:0] rready;
  logic cv [2];
  logic [1:0] ct [2];
  logic [31:0] cval [2];
  logic [1:0] ra [2];
  int checks = 0, errors = 0;

  reorder_buffer #(.DEPTH(4), .REG_NUM(32), .READ_PORTS(2), .CDB_SIZE(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dispatch_valid(dispatch_valid), .dispatch_dest(dispatch_dest),
    .dispatch_ready(dispatch_ready), .dispatch_index(dispatch_index), .cdb(cdb), .commit_stall(commit_stall),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
    .wrst(wrst), .wreorder(wreorder), .raddr(raddr), .rdata(rdata), .rready(rready), .empty(empty));

  assign cdb = {cv[1], ct[1], cval[1], cv[0], ct[0], cval[0]};
  assign raddr = {ra[1], ra[0]};

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct {int tag; int dest; logic [31:0] val; bit done;} ent_t;
  ent_t q[$];
  int nt = 0;
  bit m_rdy, m_cv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    dispatch_valid = 0; dispatch_dest = 0; commit_stall = 0; flush = 0;
    for (int s = 0; s < 2; s++) begin cv[s] = 0; ct[s] = 0; cval[s] = 0; end
  endtask

  task automatic model_check();
    m_rdy = q.size() < 4;
    m_cv = q.size() > 0 && q[0].done && !commit_stall;
    chk("m_ready", 32'(dispatch_ready), 32'(m_rdy));
    chk("m_index", 32'(dispatch_index), 32'(nt));
    chk("m_commit_valid", 32'(commit_valid), 32'(m_cv));
    chk("m_wrst", 32'(wrst), 32'(m_cv));
    chk("m_empty", 32'(empty), 32'(q.size() == 0));
    if (m_cv) begin
      chk("m_we", 32'(commit_we), 32'(q[0].dest != 0));
      chk("m_waddr", 32'(commit_waddr), 32'(q[0].dest));
      chk("m_wdata", commit_wdata, q[0].val);
      chk("m_wreorder", 32'(wreorder), 32'(q[0].tag));
    end
    for (int p = 0; p < 2; p++) begin
      bit rr = 0;
      logic [31:0] v = 0;
      foreach (q[i]) if (q[i].tag == int'(ra[p])) begin rr = q[i].done; v = q[i].val; end
      chk("m_rready", 32'(rready[p]), 32'(rr));
      if (rr) chk("m_rdata", rdata[p*32 +: 32], v);
    end
  endtask

  task automatic model_update();
    if (flush) begin
      q.delete();
      nt = 0;
    end else begin
      for (int s = 0; s < 2; s++)
        if (cv[s]) foreach (q[i]) if (q[i].tag == int'(ct[s]) && !q[i].done) begin q[i].done = 1; q[i].val = cval[s]; end
      if (m_cv) void'(q.pop_front());
      if (dispatch_valid && m_rdy) begin
        q.push_back('{tag: nt, dest: int'(dispatch_dest), val: 32'h0, done: 1'b0});
        nt = (nt + 1) % 4;
      end
    end
  endtask

  task automatic step();
    #2;
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int d);
    idle(); dispatch_valid = 1; dispatch_dest = 5'(d); step();
  endtask

  task automatic cdb0(input int t, input logic [31:0] v);
    idle(); cv[0] = 1; ct[0] = 2'(t); cval[0] = v; step();
  endtask

  task automatic do_flush();
    idle(); flush = 1; step();
  endtask

  typedef struct {
    logic dv; logic [4:0] dd; logic c; logic [1:0] t; logic [31:0] v; logic st;
    logic e_rdy; logic [1:0] e_idx; logic e_cv; logic e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic [1:0] e_wr; logic e_empty;
  } vec_t;
  vec_t tbl [13];

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 5, 0, 0, 32'h0,    0, 1, 0, 0, 0, 0, 32'h0,    0, 1};
    tbl[1]  = '{1, 6, 0, 0, 32'h0,    0, 1, 1, 0, 0, 0, 32'h0,    0, 0};
    tbl[2]  = '{0, 0, 1, 1, 32'hBBBB, 0, 1, 2, 0, 0, 0, 32'h0,    0, 0};
    tbl[3]  = '{0, 0, 1, 0, 32'hAAAA, 0, 1, 2, 0, 0, 0, 32'h0,    0, 0};
    tbl[4]  = '{0, 0, 0, 0, 32'h0,    0, 1, 2, 1, 1, 5, 32'hAAAA, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 32'h0,    0, 1, 2, 1, 1, 6, 32'hBBBB, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 32'h0,    0, 1, 2, 0, 0, 0, 32'h0,    0, 1};
    tbl[7]  = '{1, 0, 0, 0, 32'h0,    0, 1, 2, 0, 0, 0, 32'h0,    0, 1};
    tbl[8]  = '{0, 0, 1, 2, 32'h1234, 0, 1, 3, 0, 0, 0, 32'h0,    0, 0};
    tbl[9]  = '{0, 0, 0, 0, 32'h0,    1, 1, 3, 0, 0, 0, 32'h0,    0, 0};
    tbl[10] = '{0, 0, 0, 0, 32'h0,    1, 1, 3, 0, 0, 0, 32'h0,    0, 0};
    tbl[11] = '{0, 0, 0, 0, 32'h0,    0, 1, 3, 1, 0, 0, 32'h1234, 2, 0};
    tbl[12] = '{0, 0, 0, 0, 32'h0,    0, 1, 3, 0, 0, 0, 32'h0,    0, 1};
    idle();
    ra[0] = 0; ra[1] = 1;
    rst = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(dispatch_ready), 1);
    chk("rst_index", 32'(dispatch_index), 0);
    chk("rst_cv", 32'(commit_valid), 0);
    chk("rst_rready", 32'(rready), 0);
    chk("rst_rdata", rdata[31:0], 0);
    rst = 1;
    @(posedge clk);
    #1;
    foreach (tbl[r]) begin
      idle();
      dispatch_valid = tbl[r].dv; dispatch_dest = tbl[r].dd; cv[0] = tbl[r].c; ct[0] = tbl[r].t;
      cval[0] = tbl[r].v; commit_stall = tbl[r].st;
      #1;
      chk("tbl_ready", 32'(dispatch_ready), 32'(tbl[r].e_rdy));
      chk("tbl_index", 32'(dispatch_index), 32'(tbl[r].e_idx));
      chk("tbl_cv", 32'(commit_valid), 32'(tbl[r].e_cv));
      chk("tbl_wrst", 32'(wrst), 32'(tbl[r].e_cv));
      chk("tbl_empty", 32'(empty), 32'(tbl[r].e_empty));
      if (tbl[r].e_cv) begin
        chk("tbl_we", 32'(commit_we), 32'(tbl[r].e_we));
        chk("tbl_waddr", 32'(commit_waddr), 32'(tbl[r].e_wa));
        chk("tbl_wdata", commit_wdata, tbl[r].e_wd);
        chk("tbl_wreorder", 32'(wreorder), 32'(tbl[r].e_wr));
      end
      step();
    end
    // full, blocked 5th dispatch, wrap, and alloc+commit at full
    do_flush();
    for (int d = 1; d <= 4; d++) disp(d);
    idle(); dispatch_valid = 1; dispatch_dest = 7;
    #1 chk("full_ready", 32'(dispatch_ready), 0);
    step();
    chk("full_index_wrapped", 32'(dispatch_index), 0);
    chk("full_still", 32'(dispatch_ready), 0);
    cdb0(0, 32'h11);
    idle(); dispatch_valid = 1; dispatch_dest = 9;
    #1;
    chk("ac_ready", 32'(dispatch_ready), 0);
    chk("ac_cv", 32'(commit_valid), 1);
    chk("ac_waddr", 32'(commit_waddr), 1);
    step();
    chk("after_commit_ready", 32'(dispatch_ready), 1);
    chk("wrap_tag", 32'(dispatch_index), 0);
    disp(9);
    chk("refull_ready", 32'(dispatch_ready), 0);
    chk("refull_index", 32'(dispatch_index), 1);
    // flush mid-operation, stale CDB afterwards
    do_flush();
    disp(3); disp(4); disp(5);
    cdb0(0, 32'h77);
    do_flush();
    chk("flush_empty", 32'(empty), 1);
    chk("flush_index", 32'(dispatch_index), 0);
    for (int t = 0; t < 4; t += 2) begin
      ra[0] = 2'(t); ra[1] = 2'(t + 1);
      #1 chk("flush_rready", 32'(rready), 0);
    end
    cdb0(1, 32'hDEAD);
    ra[0] = 1;
    #1;
    chk("stale_rready", 32'(rready[0]), 0);
    chk("stale_empty", 32'(empty), 1);
    // asynchronous reset between edges
    disp(8); disp(9);
    cdb0(0, 32'h55);
    idle(); ra[0] = 0; ra[1] = 1;
    #2 rst = 0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_ready", 32'(dispatch_ready), 1);
    chk("arst_index", 32'(dispatch_index), 0);
    chk("arst_cv", 32'(commit_valid), 0);
    chk("arst_rready", 32'(rready), 0);
    q.delete(); nt = 0;
    #1 rst = 1;
    @(posedge clk);
    #1;
    // random traffic against the model
    for (int n = 0; n < 500; n++) begin
      idle();
      dispatch_valid = ($urandom % 3) != 0;
      dispatch_dest = 5'($urandom);
      commit_stall = ($urandom % 4) == 0;
      flush = ($urandom % 40) == 0;
      for (int s = 0; s < 2; s++) begin
        if ($urandom % 2 == 0) begin
          cv[s] = 1;
          cval[s] = $urandom;
          if (q.size() > 0 && $urandom % 4 != 0) ct[s] = 2'(q[$urandom_range(0, q.size() - 1)].tag);
          else ct[s] = 2'($urandom);
        end
        ra[s] = 2'($urandom);
      end
      if (cv[0] && cv[1] && ct[0] == ct[1]) cv[1] = 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
